cla_sub_seq: RTL and testbench
==============================

# cla_sub_seq

Multi-cycle two's-complement subtractor computing `a - b` over a WIDTH-bit word. It reuses one 4-bit carry-look-ahead adder slice and processes one nibble per clock, LSB first. It is the inverse-direction companion to the 4-bit CLA adder, for datapaths (e.g. the digit-detection accumulator/compare path) where area matters more than latency. A start/busy/done handshake makes it usable from a controlling FSM.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4
- SLICES (localparam), WIDTH/4, number of nibble iterations per operation

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend, captured on the accepting edge
- b  input  WIDTH  subtrahend, captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse: result valid/updated
- diff  output  WIDTH  a - b mod 2^WIDTH; holds until the next done
- borrow_out  output  1  1 when unsigned a < b (inverse of final carry)
- overflow  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start=1`. On that edge: latch `a`, latch `~b`, set `carry=1`, set `slice index k=0`.
  - RUN: each edge computes `{c, s} = a_nib[k] + nb_nib[k] + carry` with the 4-bit CLA. It writes `s` into the working register nibble k, stores `c` as the new carry, and increments k.
  - RUN → DONE on the edge that processes `k = SLICES-1`. On that same edge, copy the working register to `diff`, set `borrow_out = ~c`, and compute `overflow` from the latched operand MSBs.
  - DONE → IDLE unconditionally after one cycle.
- `start` in RUN or DONE is ignored. It is not queued.
- Operands are captured. Changes on `a`/`b` after the accepting edge have no effect.
- `diff`, `borrow_out` and `overflow` change only on the RUN→DONE edge. Intermediate nibbles are never visible on `diff`.
- The inter-slice carry is registered. The look-ahead applies within a nibble only.

## Timing
- Reset (asynchronous, any state): state=IDLE, k=0, carry=0, busy=0, done=0, diff=0, borrow_out=0, overflow=0. Reset during RUN aborts the operation with no done pulse.
- Let `start` be sampled high in IDLE at edge N:
  - busy=1 from edge N until edge N+SLICES.
  - done=1 from edge N+SLICES to edge N+SLICES+1.
  - Results are valid from edge N+SLICES.
- With WIDTH=16, results arrive 4 cycles after acceptance.
- Throughput: one operation per SLICES+2 cycles. With `start` held high, the next operation is accepted at edge N+SLICES+2, the first IDLE edge.
- busy and done are never high together. done is never high for more than one cycle.
- Boundary cases:
  - `a == b`: diff=0, borrow_out=0, overflow=0.
  - `b = 0`: diff=a, borrow_out=0.
  - WIDTH=4: SLICES=1, RUN lasts exactly one edge.

## Test plan
- Reset, then `a=0x1234, b=0x0234, start` pulse → after 4 edges: done=1 for 1 cycle, diff=0x1000, borrow_out=0, overflow=0; busy high exactly 4 cycles.
- `a=0x0000, b=0x0001` → diff=0xFFFF, borrow_out=1, overflow=0. Then `a=0x1000, b=0x0001` → diff=0x0FFF (borrow ripples through all nibbles), borrow_out=0.
- `a=0x8000, b=0x0001` → diff=0x7FFF, overflow=1, borrow_out=0. `a=0x7FFF, b=0xFFFF` → diff=0x8000, overflow=1, borrow_out=1.
- Start `a=0xF0F0, b=0x0F0F`. Change `a`/`b` and pulse `start` again during RUN → diff=0xE1E1; the second start is ignored and only one done pulse occurs.
- `start` held high continuously with fixed operands → done pulses every 6 cycles, busy low during each DONE and IDLE cycle.
- Assert rst_n=0 two cycles into RUN, then release → all outputs 0, no done. A fresh start then completes normally in 4 cycles.

Source files
------------

// File: rtl/cla_sub_seq.sv
// Nibble-serial two's-complement subtractor: a - b computed LSB-first through one
// 4-bit carry-look-ahead slice, with a start/busy/done handshake.
module cla_sub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int SLICES = WIDTH / 4;
  localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic [3:0] a_nib, b_nib, g, p, sum_nib;
  logic [4:0] cy;
  logic       last_slice;

  // Operand nibble selection by slice index, decoded rather than variably indexed.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < SLICES; i++) begin
      if (k_q == KW'(i)) begin
        a_nib = a_q[i*4 +: 4];
        b_nib = nb_q[i*4 +: 4];
      end
    end
  end

  // 4-bit carry-look-ahead slice; the carry between slices is registered.
  always_comb begin
    g     = a_nib & b_nib;
    p     = a_nib ^ b_nib;
    cy[0] = carry_q;
    cy[1] = g[0] | (p[0] & cy[0]);
    cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cy[0]);
    cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cy[0]);
    cy[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & cy[0]);
    sum_nib = p ^ cy[3:0];
  end

  assign last_slice = (k_q == KW'(SLICES - 1));

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    a_d      = a_q;
    nb_d     = nb_q;
    work_d   = work_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          k_d     = '0;
        end
      end
      RUN: begin
        for (int i = 0; i < SLICES; i++) begin
          if (k_q == KW'(i)) work_d[i*4 +: 4] = sum_nib;
        end
        carry_d = cy[4];
        if (last_slice) begin
          state_d  = DONE;
          k_d      = '0;
          diff_d   = work_d;
          borrow_d = ~cy[4];
          // The subtrahend MSB is the complement of the latched ~b MSB.
          ovf_d    = (a_q[WIDTH-1] != ~nb_q[WIDTH-1]) && (sum_nib[3] != a_q[WIDTH-1]);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      nb_q     <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cla_sub_seq.sv
// Directed bench for cla_sub_seq (WIDTH=16): hand-computed vectors, handshake timing,
// operand capture, back-to-back operation and reset abort.
module tb_cla_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, borrow_out, overflow;
  logic [15:0] diff;

  int total = 0;
  int bad = 0;

  cla_sub_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: start pulse, count busy cycles, check result, done width and hold.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ed, input logic eb, input logic eo);
    int busy_cnt;
    bit got;
    busy_cnt = 0;
    got = 0;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy && done) chk({tag, "_busy_and_done"}, 1, 0);
      if (done) begin got = 1; break; end
      if (busy) busy_cnt++;
    end
    chk({tag, "_done_seen"}, 32'(got), 1);
    chk({tag, "_busy_cycles"}, busy_cnt, 4);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow_out, eb);
    chk({tag, "_ovf"}, overflow, eo);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    @(negedge clk);
    chk({tag, "_diff_hold"}, diff, ed);
    $display("op %s: a=%h b=%h diff=%h borrow=%b ovf=%b", tag, av, bv, diff, borrow_out, overflow);
  endtask

  initial begin
    int done_cnt;
    int last_done;
    int busy_cnt;
    int dones_seen;

    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {borrow_out, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic",    16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
    run_op("neg1",     16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    run_op("ripple",   16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0);
    run_op("ovf_pos",  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    run_op("ovf_neg",  16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
    run_op("equal",    16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b0);
    run_op("b_zero",   16'hABCD, 16'h0000, 16'hABCD, 1'b0, 1'b0);

    // Operands captured; start during RUN ignored.
    @(negedge clk);
    a = 16'hF0F0; b = 16'h0F0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'h1111; b = 16'h2222;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        chk("capture_diff", diff, 16'hE1E1);
      end
    end
    chk("capture_one_done", done_cnt, 1);
    $display("op capture: diff=%h dones=%0d", diff, done_cnt);

    // Start held high: one operation per 6 cycles.
    @(negedge clk);
    a = 16'h9000; b = 16'h1000; start = 1'b1;
    last_done = -1;
    busy_cnt = 0;
    dones_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy && done) chk("held_busy_and_done", 1, 0);
      if (done) begin
        if (last_done >= 0) chk("held_period", i - last_done, 6);
        if (dones_seen == 1) chk("held_busy_per_op", busy_cnt, 4);
        chk("held_diff", diff, 16'h8000);
        last_done = i;
        dones_seen++;
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end
    end
    chk("held_done_count", dones_seen, 3);
    start = 1'b0;
    $display("op held: dones=%0d diff=%h", dones_seen, diff);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) break;
    end
    @(negedge clk);

    // Reset two cycles into RUN aborts with no done pulse.
    a = 16'h1234; b = 16'h0234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_in_run", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_flags", {borrow_out, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("abort_quiet", done_cnt, 0);
    $display("op abort: diff=%h", diff);
    run_op("after_rst", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
